// File: rtl/register_file_mp_pkg.sv
// regfile_pkg: shared state type, default sizes and packed-port slicing helper for register_file_mp
package regfile_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} rf_state_t;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH = 32;
  function automatic int unsigned slot_lsb(int unsigned p, int unsigned w);
    return p * w;
  endfunction
endpackage

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: clr/ready plus write ports (wen/wsel/wdat) and read ports (rsel/rdat); master drives, slave is the register file
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  parameter int NWRITE = 2
);
  localparam int AW = $clog2(DEPTH);
  logic clr;
  logic ready;
  logic [NWRITE-1:0] wen;
  logic [NWRITE*AW-1:0] wsel;
  logic [NWRITE*DATA_W-1:0] wdat;
  logic [NREAD*AW-1:0] rsel;
  logic [NREAD*DATA_W-1:0] rdat;
  modport master(output clr, wen, wsel, wdat, rsel, input ready, rdat);
  modport slave(input clr, wen, wsel, wdat, rsel, output ready, rdat);
endinterface

// File: rtl/register_file_mp_sweep.sv
// regfile_sweep_ctrl: CLEAR/RUN FSM and sweep pointer; in CLK, RST, clr; out ready, clr_we (clear-write strobe), clr_addr
module regfile_sweep_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  rf_state_t state;
  logic [AW-1:0] ptr;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR;
      ptr <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + AW'(1);
      if (ptr == AW'(DEPTH - 1)) state <= RUN;
    end else if (clr) begin
      state <= CLEAR;
      ptr <= '0;
    end
  end
  assign ready = state == RUN;
  assign clr_we = state == CLEAR && !RST;
  assign clr_addr = ptr;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with bypass, writer priority and clear sweep; in CLK, RST; bus (slave) carries clr/ready, write and read ports
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH = RF_DEPTH,
  parameter int NREAD = 2,
  parameter int NWRITE = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic CLK,
  input logic RST,
  register_file_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic ready;
  logic clr_we;
  logic [AW-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  regfile_sweep_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .CLK(CLK),
    .RST(RST),
    .clr(bus.clr),
    .ready(ready),
    .clr_we(clr_we),
    .clr_addr(clr_addr)
  );
  assign bus.ready = ready;
  // later ports overwrite earlier ones in the loop, giving the higher index priority
  always_ff @(posedge CLK) begin
    if (clr_we) mem[clr_addr] <= '0;
    else if (ready && !bus.clr && !RST)
      for (int p = 0; p < NWRITE; p++)
        if (bus.wen[p] && !(ZERO_REG != 0 && bus.wsel[slot_lsb(p, AW) +: AW] == '0))
          mem[bus.wsel[slot_lsb(p, AW) +: AW]] <= bus.wdat[slot_lsb(p, DATA_W) +: DATA_W];
  end
  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic [AW-1:0] a;
    logic [DATA_W-1:0] v;
    always_comb begin
      a = bus.rsel[slot_lsb(r, AW) +: AW];
      v = mem[a];
      if (BYPASS != 0)
        for (int p = 0; p < NWRITE; p++)
          if (bus.wen[p] && bus.wsel[slot_lsb(p, AW) +: AW] == a)
            v = bus.wdat[slot_lsb(p, DATA_W) +: DATA_W];
      if (!ready || (ZERO_REG != 0 && a == '0)) v = '0;
    end
    assign bus.rdat[slot_lsb(r, DATA_W) +: DATA_W] = v;
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: scoreboard bench for a default instance and a DEPTH=8/NREAD=3/NWRITE=1/BYPASS=0 instance
module tb_register_file_mp;
  logic CLK = 0;
  logic RST = 1;
  always #5 CLK = ~CLK;
  register_file_mp_if #(.DATA_W(32), .DEPTH(32), .NREAD(2), .NWRITE(2)) ifa ();
  register_file_mp_if #(.DATA_W(32), .DEPTH(8), .NREAD(3), .NWRITE(1)) ifb ();
  register_file_mp u_a (.CLK(CLK), .RST(RST), .bus(ifa));
  register_file_mp #(.DEPTH(8), .NREAD(3), .NWRITE(1), .BYPASS(0)) u_b (.CLK(CLK), .RST(RST), .bus(ifb));
  localparam int DEP [2] = '{32, 8};
  localparam int NR [2] = '{2, 3};
  localparam int NW [2] = '{2, 1};
  localparam int BYP [2] = '{1, 0};
  logic clr_v [2];
  logic wen_v [2][2];
  logic [4:0] wsel_v [2][2];
  logic [31:0] wdat_v [2][2];
  logic [4:0] rsel_v [2][3];
  logic [31:0] mem [2][32];
  int left [2] = '{-1, -1};
  always_comb begin
    ifa.clr = clr_v[0];
    ifb.clr = clr_v[1];
    for (int p = 0; p < 2; p++) begin
      ifa.wen[p] = wen_v[0][p];
      ifa.wsel[p*5 +: 5] = wsel_v[0][p];
      ifa.wdat[p*32 +: 32] = wdat_v[0][p];
      ifa.rsel[p*5 +: 5] = rsel_v[0][p];
    end
    ifb.wen[0] = wen_v[1][0];
    ifb.wsel = wsel_v[1][0][2:0];
    ifb.wdat = wdat_v[1][0];
    for (int r = 0; r < 3; r++) ifb.rsel[r*3 +: 3] = rsel_v[1][r][2:0];
  end
  typedef struct {int cyc; int d; int idx; logic [31:0] exp;} item_t;
  item_t q [$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic logic [31:0] act(int d, int idx);
    if (idx < 0) return d == 0 ? 32'(ifa.ready) : 32'(ifb.ready);
    return d == 0 ? ifa.rdat[idx*32 +: 32] : ifb.rdat[idx*32 +: 32];
  endfunction
  always @(negedge CLK) begin : mon
    item_t it;
    logic [31:0] a;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      a = act(it.d, it.idx);
      total++;
      if (a !== it.exp || it.cyc != cyc) begin
        bad++;
        if (it.idx < 0) $display("FAIL dut%0d ready cyc=%0d actual=%h required=%h", it.d, it.cyc, a, it.exp);
        else $display("FAIL dut%0d rdat%0d cyc=%0d actual=%h required=%h", it.d, it.idx, it.cyc, a, it.exp);
      end
    end
  end
  function automatic logic [31:0] exp_rd(int d, int r);
    int a = int'(rsel_v[d][r]);
    logic [31:0] v;
    if (left[d] != 0 || a == 0) return '0;
    v = mem[d][a];
    if (BYP[d] != 0)
      for (int p = 0; p < NW[d]; p++)
        if (wen_v[d][p] && int'(wsel_v[d][p]) == a) v = wdat_v[d][p];
    return v;
  endfunction
  task automatic update(int d);
    if (RST) left[d] = DEP[d];
    else if (left[d] > 0) begin
      left[d]--;
      if (left[d] == 0) for (int a = 0; a < 32; a++) mem[d][a] = '0;
    end else if (left[d] == 0 && clr_v[d]) left[d] = DEP[d];
    else if (left[d] == 0)
      for (int p = 0; p < NW[d]; p++)
        if (wen_v[d][p] && wsel_v[d][p] != 0) mem[d][wsel_v[d][p]] = wdat_v[d][p];
  endtask
  task automatic step();
    for (int d = 0; d < 2; d++)
      if (left[d] >= 0) begin
        q.push_back('{cyc, d, -1, 32'(left[d] == 0)});
        for (int r = 0; r < NR[d]; r++) q.push_back('{cyc, d, r, exp_rd(d, r)});
      end
    @(posedge CLK);
    for (int d = 0; d < 2; d++) update(d);
    #1;
  endtask
  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      clr_v[d] = 0;
      for (int p = 0; p < 2; p++) wen_v[d][p] = 0;
    end
  endtask
  task automatic read_all();
    idle();
    for (int a = 0; a < 32; a++) begin
      rsel_v[0][0] = 5'(a);
      rsel_v[0][1] = 5'(31 - a);
      for (int r = 0; r < 3; r++) rsel_v[1][r] = 5'((a + r) % 8);
      step();
    end
  endtask
  initial begin
    idle();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        wsel_v[d][p] = '0;
        wdat_v[d][p] = '0;
      end
    for (int d = 0; d < 2; d++) for (int r = 0; r < 3; r++) rsel_v[d][r] = '0;
    RST = 1;
    step();
    step();
    RST = 0;
    repeat (34) step();
    read_all();
    wen_v[0][0] = 1; wsel_v[0][0] = 5; wdat_v[0][0] = 32'hDEADBEEF;
    rsel_v[0][0] = 5; rsel_v[0][1] = 5;
    step(); idle(); step();
    wen_v[0][0] = 1; wsel_v[0][0] = 0; wdat_v[0][0] = 32'h1234;
    rsel_v[0][0] = 0; rsel_v[0][1] = 0;
    step(); idle(); step();
    wen_v[0][0] = 1; wsel_v[0][0] = 7; wdat_v[0][0] = 32'hAAAA0000;
    wen_v[0][1] = 1; wsel_v[0][1] = 7; wdat_v[0][1] = 32'h0000BBBB;
    rsel_v[0][0] = 7; rsel_v[0][1] = 7;
    step(); idle(); step();
    wen_v[1][0] = 1; wsel_v[1][0] = 3; wdat_v[1][0] = 32'h55;
    for (int r = 0; r < 3; r++) rsel_v[1][r] = 3;
    step(); idle(); step();
    repeat (400) begin
      for (int d = 0; d < 2; d++) begin
        clr_v[d] = $urandom_range(0, 59) == 0;
        for (int p = 0; p < 2; p++) begin
          wen_v[d][p] = 1'($urandom_range(0, 1));
          wsel_v[d][p] = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, DEP[d] - 1));
          wdat_v[d][p] = $urandom;
        end
        for (int r = 0; r < 3; r++)
          rsel_v[d][r] = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, DEP[d] - 1));
      end
      step();
    end
    idle();
    repeat (34) step();
    for (int a = 1; a < 32; a++) begin
      idle();
      wen_v[0][a % 2] = 1; wsel_v[0][a % 2] = 5'(a); wdat_v[0][a % 2] = 32'(a) * 32'h01010101 | 32'h1;
      wen_v[1][0] = 1; wsel_v[1][0] = 5'(a % 8); wdat_v[1][0] = 32'(a) << 4 | 32'h1;
      step();
    end
    idle();
    clr_v[0] = 1; clr_v[1] = 1;
    wen_v[0][0] = 1; wsel_v[0][0] = 9; wdat_v[0][0] = 32'hBAD;
    rsel_v[0][0] = 9; rsel_v[0][1] = 10;
    step();
    idle();
    repeat (34) step();
    read_all();
    RST = 1; step(); RST = 0;
    repeat (10) step();
    RST = 1; step(); RST = 0;
    repeat (34) step();
    read_all();
    @(negedge CLK);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
